mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 81 ++++++++
 tb/tb_mem_arbiter.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter shared by dcache and icache: one byte access per cycle,
// dcache has fixed priority, and each completion is strobed one cycle after its grant.
module mem_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        d_get_en,
  input  logic        d_write_mode,
  input  logic [17:0] d_addr,
  input  logic [7:0]  d_wdata,
  output logic        d_out_en,
  output logic [7:0]  d_rdata,
  input  logic        i_get_en,
  input  logic [17:0] i_addr,
  output logic        i_out_en,
  output logic [7:0]  i_rdata,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_a,
  output logic [7:0]  mem_dout,
  output logic        mem_wr
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DCACHE = 2'd1,
    ICACHE = 2'd2
  } owner_e;

  owner_e      state_q, state_d;
  logic [31:0] d_grants_q, d_grants_d;
  logic [31:0] i_grants_q, i_grants_d;
  logic        grant_d, grant_i;

  always_comb begin
    grant_d = rdy & ~rst & d_get_en;
    grant_i = rdy & ~rst & ~d_get_en & i_get_en;
  end

  // The owner register remembers who was granted last cycle; that is the only
  // completion that can be pending, so out_en never needs a queue.
  always_comb begin
    state_d    = IDLE;
    mem_a      = 32'h0;
    mem_dout   = 8'h0;
    mem_wr     = 1'b0;
    d_grants_d = d_grants_q;
    i_grants_d = i_grants_q;
    if (grant_d) begin
      state_d    = DCACHE;
      mem_a      = {14'b0, d_addr};
      mem_dout   = d_wdata;
      mem_wr     = d_write_mode;
      d_grants_d = d_grants_q + 32'd1;
    end else if (grant_i) begin
      state_d    = ICACHE;
      mem_a      = {14'b0, i_addr};
      i_grants_d = i_grants_q + 32'd1;
    end
  end

  // A reset cycle discards the in-flight access, so its completion is suppressed.
  always_comb begin
    d_out_en = (state_q == DCACHE) & ~rst;
    i_out_en = (state_q == ICACHE) & ~rst;
    d_rdata  = d_out_en ? mem_din : 8'h0;
    i_rdata  = i_out_en ? mem_din : 8'h0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      d_grants_q <= 32'h0;
      i_grants_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      d_grants_q <= d_grants_d;
      i_grants_q <= i_grants_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter, checked against a transaction-level
// model: last issued access, its address/kind, and grant totals.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst, rdy;
  logic        d_get_en, d_write_mode;
  logic [17:0] d_addr;
  logic [7:0]  d_wdata;
  logic        d_out_en;
  logic [7:0]  d_rdata;
  logic        i_get_en;
  logic [17:0] i_addr;
  logic        i_out_en;
  logic [7:0]  i_rdata;
  logic [7:0]  mem_din;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .d_get_en(d_get_en), .d_write_mode(d_write_mode), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_out_en(d_out_en), .d_rdata(d_rdata),
    .i_get_en(i_get_en), .i_addr(i_addr), .i_out_en(i_out_en), .i_rdata(i_rdata),
    .mem_din(mem_din), .mem_a(mem_a), .mem_dout(mem_dout), .mem_wr(mem_wr)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: who was issued last cycle (0 none, 1 dcache, 2 icache).
  int          lastWho = 0;
  logic [17:0] lastAddr = '0;
  bit          lastWr = 1'b0;
  int unsigned dCount = 0;
  int unsigned iCount = 0;

  logic        obsDOut, obsIOut, obsWr;
  logic [7:0]  obsDR, obsIR, obsDout;
  logic [31:0] obsMemA;

  function automatic logic [7:0] ramByte(input logic [17:0] a);
    case (a)
      18'h100: return 8'hAA;
      18'h101: return 8'hBB;
      18'h102: return 8'hCC;
      18'h103: return 8'hDD;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: drive at negedge, check combinational outputs, then check counters after the edge.
  task automatic applyStimulus(input bit r, input bit rv, input bit dg, input bit dw,
                               input logic [17:0] da, input logic [7:0] dd,
                               input bit ig, input logic [17:0] ia);
    bit          gd, gi, expDOut, expIOut;
    logic [7:0]  din;
    logic [31:0] expA;
    @(negedge clk);
    rst = r; rdy = rv;
    d_get_en = dg; d_write_mode = dw; d_addr = da; d_wdata = dd;
    i_get_en = ig; i_addr = ia;
    if (lastWho == 0)  din = 8'($urandom);
    else if (lastWr)   din = 8'h00;
    else               din = ramByte(lastAddr);
    mem_din = din;
    #1;
    obsDOut = d_out_en; obsIOut = i_out_en; obsDR = d_rdata; obsIR = i_rdata;
    obsMemA = mem_a; obsWr = mem_wr; obsDout = mem_dout;

    gd = !r && rv && dg;
    gi = !r && rv && !dg && ig;
    expDOut = !r && (lastWho == 1);
    expIOut = !r && (lastWho == 2);
    expA = gd ? {14'b0, da} : (gi ? {14'b0, ia} : 32'h0);
    checkOutput("d_out_en", obsDOut, expDOut);
    checkOutput("i_out_en", obsIOut, expIOut);
    checkOutput("d_rdata", obsDR, expDOut ? din : 8'h0);
    checkOutput("i_rdata", obsIR, expIOut ? din : 8'h0);
    checkOutput("mem_a", obsMemA, expA);
    checkOutput("mem_wr", obsWr, gd && dw);
    checkOutput("mem_dout", obsDout, gd ? dd : 8'h0);
    checkOutput("out_en_excl", obsDOut & obsIOut, 0);

    lastWho  = gd ? 1 : (gi ? 2 : 0);
    lastAddr = expA[17:0];
    lastWr   = gd && dw;
    if (r) begin
      dCount = 0; iCount = 0;
    end else begin
      dCount += gd; iCount += gi;
    end
    @(posedge clk);
    #1;
    checkOutput("d_grants", dut.d_grants_q, dCount);
    checkOutput("i_grants", dut.i_grants_q, iCount);
  endtask

  initial begin
    logic [17:0] iaddr;
    logic [7:0]  got[$];
    logic [7:0]  expB[4];
    int          firstK, lastK, stallOut;
    bit          rv;
    expB = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};

    rst = 1'b1; rdy = 1'b0; d_get_en = 1'b0; d_write_mode = 1'b0; d_addr = '0; d_wdata = '0;
    i_get_en = 1'b0; i_addr = '0; mem_din = '0;
    applyStimulus(1, 1, 1, 1, 18'h1234, 8'h55, 1, 18'h10);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);

    // Icache burst, address advancing on each completion
    iaddr = 18'h100; firstK = -1; lastK = -1;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 0, 0, 0, 0, iaddr <= 18'h103, iaddr);
      if (obsIOut) begin
        got.push_back(obsIR);
        if (firstK < 0) firstK = k;
        lastK = k;
      end
      if (i_out_en) iaddr++;
    end
    checkOutput("burst_count", got.size(), 4);
    checkOutput("burst_first", firstK, 1);
    checkOutput("burst_last", lastK, 4);
    for (int i = 0; i < 4 && i < got.size(); i++) checkOutput("burst_byte", got[i], expB[i]);

    // Collision: dcache wins, icache byte follows
    applyStimulus(0, 1, 1, 0, 18'h200, 0, 1, 18'h100);
    checkOutput("coll_mem_a", obsMemA, 32'h200);
    applyStimulus(0, 1, 0, 0, 0, 0, 1, 18'h100);
    checkOutput("coll_d_out", obsDOut, 1);
    checkOutput("coll_i_early", obsIOut, 0);
    checkOutput("coll_i_addr", obsMemA, 32'h100);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("coll_i_out", obsIOut, 1);
    checkOutput("coll_i_data", obsIR, 8'hAA);

    // IO write
    applyStimulus(0, 1, 1, 1, 18'h30000, 8'h41, 0, 0);
    checkOutput("wr_mem_wr", obsWr, 1);
    checkOutput("wr_mem_a", obsMemA, 32'h0003_0000);
    checkOutput("wr_mem_dout", obsDout, 8'h41);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("wr_d_out", obsDOut, 1);
    checkOutput("wr_d_rdata", obsDR, 8'h00);

    // rdy stall in the middle of an icache burst
    got.delete(); iaddr = 18'h100; stallOut = 0;
    for (int k = 0; k < 10; k++) begin
      rv = !(k >= 2 && k <= 4);
      applyStimulus(0, rv, 0, 0, 0, 0, iaddr <= 18'h103, iaddr);
      if (obsIOut) got.push_back(obsIR);
      if (!rv) begin
        stallOut += obsIOut;
        checkOutput("stall_mem_wr", obsWr, 0);
        checkOutput("stall_mem_a", obsMemA, 0);
      end
      if (i_out_en) iaddr++;
    end
    checkOutput("stall_pending", stallOut, 1);
    checkOutput("stall_count", got.size(), 4);
    for (int i = 0; i < 4 && i < got.size(); i++) checkOutput("stall_byte", got[i], expB[i]);

    // Reset in the middle of a dcache read burst
    applyStimulus(0, 1, 1, 0, 18'h100, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 18'h101, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 18'h102, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_d_out", obsDOut, 0);
    checkOutput("rst_d_rdata", obsDR, 0);
    checkOutput("rst_mem_a", obsMemA, 0);
    applyStimulus(0, 1, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_idle", obsDOut | obsIOut, 0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      logic [17:0] da, ia;
      da = ($urandom_range(0, 3) == 0) ? (18'h30000 | 18'($urandom_range(0, 16'hFFFF)))
                                       : 18'($urandom);
      ia = 18'($urandom);
      applyStimulus($urandom_range(0, 31) == 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                    da, 8'($urandom), $urandom_range(0, 1) == 1, ia);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
